// File: rtl/master_start_seq_if.sv
// DDS programming bundle: frequency/step/rate data, four-phase REQ/ACK handshake and run strobe.
interface master_start_seq_if #(
  parameter int FW = 48,
  parameter int RW = 32
);
  logic [FW-1:0] DDS_FREQ;
  logic [FW-1:0] DDS_DFREQ;
  logic [RW-1:0] DDS_RATE;
  logic          DDS_REQ;
  logic          DDS_ACK;
  logic          DDS_START;

  modport master (output DDS_FREQ, DDS_DFREQ, DDS_RATE, DDS_REQ, DDS_START, input DDS_ACK);
  modport slave  (input DDS_FREQ, DDS_DFREQ, DDS_RATE, DDS_REQ, DDS_START, output DDS_ACK);
endinterface

// File: rtl/master_start_seq.sv
// Radar master-start sequencer: second-aligned system time, queued timed burst commands,
// DDS programming handshake and blank/emit/blank/receive pulse train generation.
module master_start_seq #(
  parameter int TW    = 64,
  parameter int FW    = 48,
  parameter int RW    = 32,
  parameter int IW    = 32,
  parameter int NW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     T1HZ,
  input  logic                     TIME_ARM,
  input  logic [TW-1:0]            SYS_TIME_SET,
  input  logic                     CMD_WR,
  input  logic [TW-1:0]            CMD_TSTART,
  input  logic [NW-1:0]            CMD_N,
  input  logic                     CMD_MODE,
  input  logic [FW-1:0]            CMD_FREQ,
  input  logic [FW-1:0]            CMD_DFREQ,
  input  logic [RW-1:0]            CMD_RATE,
  input  logic [IW-1:0]            CMD_TB1,
  input  logic [IW-1:0]            CMD_TI,
  input  logic [IW-1:0]            CMD_TB2,
  input  logic [IW-1:0]            CMD_TP,
  input  logic                     ABORT,
  master_start_seq_if.master       dds,
  output logic                     EN_IZ,
  output logic                     EN_PR,
  output logic [TW-1:0]            TIME,
  output logic                     TIME_VALID,
  output logic [$clog2(DEPTH):0]   CMD_LEVEL,
  output logic                     CMD_FULL,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     LATE_ERR,
  output logic                     OVF
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, ACKW, BLANK1, IZL, BLANK2, PR} state_t;

  typedef struct packed {
    logic [TW-1:0] tstart;
    logic [NW-1:0] n;
    logic          mode;
    logic [FW-1:0] freq;
    logic [FW-1:0] dfreq;
    logic [RW-1:0] rate;
    logic [IW-1:0] tb1;
    logic [IW-1:0] ti;
    logic [IW-1:0] tb2;
    logic [IW-1:0] tp;
  } cmd_t;

  state_t        state, state_next;
  logic [2:0]    t1_sync;
  logic          arm_d, sec_edge, arm_rise, kill;
  logic [TW-1:0] time_q;
  logic          time_valid;
  logic [LW-1:0] wr_ptr, rd_ptr, level;
  logic          full, empty, push, pop;
  cmd_t          mem [DEPTH];
  cmd_t          head, in_cmd;
  logic [TW-1:0] cur_tstart;
  logic [NW-1:0] cur_n, pulse_cnt;
  logic          cur_mode;
  logic [FW-1:0] cur_freq, cur_dfreq;
  logic [RW-1:0] cur_rate;
  logic [IW-1:0] cur_tb1, cur_ti, cur_tb2, cur_tp;
  logic [IW-1:0] iv_cnt, iv_load;
  logic          iv_zero, done_set, late_set;
  logic          dds_req, dds_start, en_iz, en_pr;

  assign sec_edge = t1_sync[1] & ~t1_sync[2];
  assign arm_rise = TIME_ARM & ~arm_d;
  // Losing time validity mid-burst tears the burst down like an abort, but keeps the queue.
  assign kill     = ABORT | (arm_rise & time_valid);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      t1_sync    <= '0;
      arm_d      <= 1'b0;
      time_q     <= '0;
      time_valid <= 1'b0;
    end else begin
      t1_sync <= {t1_sync[1:0], T1HZ};
      arm_d   <= TIME_ARM;
      if (sec_edge && !time_valid) time_q <= SYS_TIME_SET;
      else                         time_q <= time_q + TW'(1);
      if (arm_rise)      time_valid <= 1'b0;
      else if (sec_edge) time_valid <= 1'b1;
    end
  end

  assign in_cmd = '{tstart: CMD_TSTART, n: CMD_N, mode: CMD_MODE, freq: CMD_FREQ,
                    dfreq: CMD_DFREQ, rate: CMD_RATE, tb1: CMD_TB1, ti: CMD_TI,
                    tb2: CMD_TB2, tp: CMD_TP};
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign push   = CMD_WR & ~full & ~ABORT;
  assign head   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_cmd;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      OVF    <= 1'b0;
    end else begin
      OVF <= CMD_WR & full & ~ABORT;
      if (ABORT) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + LW'(1);
        if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  assign iv_zero = (iv_cnt == '0);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done_set   = 1'b0;
    late_set   = 1'b0;
    case (state)
      IDLE:   if (time_valid && !empty) begin
                pop        = 1'b1;
                state_next = WAIT;
              end
      WAIT:   if (time_q == cur_tstart) begin
                if (pulse_cnt == '0) begin
                  done_set   = 1'b1;
                  state_next = IDLE;
                end else begin
                  state_next = LOAD;
                end
              end else if (time_q > cur_tstart) begin
                late_set   = 1'b1;
                state_next = IDLE;
              end
      LOAD:   if (dds.DDS_ACK)  state_next = ACKW;
      ACKW:   if (!dds.DDS_ACK) state_next = BLANK1;
      BLANK1: if (iv_zero) state_next = IZL;
      IZL:    if (iv_zero) state_next = BLANK2;
      BLANK2: if (iv_zero) state_next = PR;
      PR:     if (iv_zero) begin
                if (pulse_cnt > NW'(1)) begin
                  state_next = cur_mode ? BLANK1 : LOAD;
                end else begin
                  done_set   = 1'b1;
                  state_next = IDLE;
                end
              end
      default: state_next = IDLE;
    endcase
    if (kill) begin
      state_next = IDLE;
      pop        = 1'b0;
      done_set   = 1'b0;
      late_set   = 1'b0;
    end
  end

  // In coherent mode the DDS keeps running across pulses; only the first BLANK1 precedes the run.
  always_comb begin
    dds_req   = 1'b0;
    dds_start = 1'b0;
    en_iz     = 1'b0;
    en_pr     = 1'b0;
    case (state)
      LOAD:   dds_req   = 1'b1;
      BLANK1: dds_start = cur_mode & (pulse_cnt != cur_n);
      IZL:    begin
                dds_start = 1'b1;
                en_iz     = 1'b1;
              end
      BLANK2: dds_start = cur_mode & (pulse_cnt > NW'(1));
      PR:     begin
                dds_start = cur_mode & (pulse_cnt > NW'(1));
                en_pr     = 1'b1;
              end
      default: ;
    endcase
  end

  always_comb begin
    iv_load = '0;
    case (state_next)
      BLANK1:  iv_load = cur_tb1;
      IZL:     iv_load = cur_ti;
      BLANK2:  iv_load = cur_tb2;
      PR:      iv_load = cur_tp;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      iv_cnt   <= '0;
      DONE     <= 1'b0;
      LATE_ERR <= 1'b0;
    end else begin
      DONE     <= done_set;
      LATE_ERR <= late_set;
      if (state_next != state) iv_cnt <= iv_load;
      else if (!iv_zero)       iv_cnt <= iv_cnt - IW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_tstart <= '0;
      cur_n      <= '0;
      pulse_cnt  <= '0;
      cur_mode   <= 1'b0;
      cur_freq   <= '0;
      cur_dfreq  <= '0;
      cur_rate   <= '0;
      cur_tb1    <= '0;
      cur_ti     <= '0;
      cur_tb2    <= '0;
      cur_tp     <= '0;
    end else if (pop) begin
      cur_tstart <= head.tstart;
      cur_n      <= head.n;
      pulse_cnt  <= head.n;
      cur_mode   <= head.mode;
      cur_freq   <= head.freq;
      cur_dfreq  <= head.dfreq;
      cur_rate   <= head.rate;
      cur_tb1    <= head.tb1;
      cur_ti     <= head.ti;
      cur_tb2    <= head.tb2;
      cur_tp     <= head.tp;
    end else if (state == PR && iv_zero) begin
      pulse_cnt <= pulse_cnt - NW'(1);
    end
  end

  assign dds.DDS_FREQ  = cur_freq;
  assign dds.DDS_DFREQ = cur_dfreq;
  assign dds.DDS_RATE  = cur_rate;
  assign dds.DDS_REQ   = dds_req;
  assign dds.DDS_START = dds_start;
  assign EN_IZ         = en_iz;
  assign EN_PR         = en_pr;
  assign TIME          = time_q;
  assign TIME_VALID    = time_valid;
  assign CMD_LEVEL     = level;
  assign CMD_FULL      = full;
  assign BUSY          = (state != IDLE);
endmodule

// File: tb/tb_master_start_seq.sv
// Directed bench for master_start_seq: time loading, incoherent/coherent bursts, late rejection,
// queue overflow and ordering, abort and reset mid-handshake.
`timescale 1ns/1ps
module tb_master_start_seq;
  localparam int TW = 64, FW = 48, RW = 32, IW = 32, NW = 16, DEPTH = 8;

  logic CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic                 RESET, T1HZ, TIME_ARM, CMD_WR, CMD_MODE, ABORT;
  logic [TW-1:0]        SYS_TIME_SET, CMD_TSTART, TIME;
  logic [NW-1:0]        CMD_N;
  logic [FW-1:0]        CMD_FREQ, CMD_DFREQ;
  logic [RW-1:0]        CMD_RATE;
  logic [IW-1:0]        CMD_TB1, CMD_TI, CMD_TB2, CMD_TP;
  logic                 EN_IZ, EN_PR, TIME_VALID, CMD_FULL, BUSY, DONE, LATE_ERR, OVF;
  logic [$clog2(DEPTH):0] CMD_LEVEL;

  master_start_seq_if #(.FW(FW), .RW(RW)) dds ();

  master_start_seq #(.TW(TW), .FW(FW), .RW(RW), .IW(IW), .NW(NW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .T1HZ(T1HZ), .TIME_ARM(TIME_ARM), .SYS_TIME_SET(SYS_TIME_SET),
    .CMD_WR(CMD_WR), .CMD_TSTART(CMD_TSTART), .CMD_N(CMD_N), .CMD_MODE(CMD_MODE),
    .CMD_FREQ(CMD_FREQ), .CMD_DFREQ(CMD_DFREQ), .CMD_RATE(CMD_RATE), .CMD_TB1(CMD_TB1),
    .CMD_TI(CMD_TI), .CMD_TB2(CMD_TB2), .CMD_TP(CMD_TP), .ABORT(ABORT), .dds(dds),
    .EN_IZ(EN_IZ), .EN_PR(EN_PR), .TIME(TIME), .TIME_VALID(TIME_VALID), .CMD_LEVEL(CMD_LEVEL),
    .CMD_FULL(CMD_FULL), .BUSY(BUSY), .DONE(DONE), .LATE_ERR(LATE_ERR), .OVF(OVF)
  );

  int vec_count, miscompares;
  int req_rises, start_rises, start_cycles, iz_cycles, pr_cycles;
  int done_cnt, late_cnt, ovf_cnt, overlap, unstable, req_age;
  logic req_prev = 1'b0, start_prev = 1'b0;
  logic [63:0] req_times[$];
  logic [FW-1:0] req_freqs[$];
  logic [FW-1:0] lat_freq, lat_dfreq;
  logic [RW-1:0] lat_rate;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // DDS model: acknowledges two cycles into a request and releases once the request drops.
  always @(negedge CLK) begin
    if (RESET || !dds.DDS_REQ) begin
      dds.DDS_ACK = 1'b0;
      req_age = 0;
    end else begin
      req_age++;
      if (req_age >= 2) dds.DDS_ACK = 1'b1;
    end
  end

  always @(posedge CLK) begin
    #2;
    if (dds.DDS_REQ && !req_prev) begin
      req_rises++;
      req_times.push_back(TIME);
      req_freqs.push_back(dds.DDS_FREQ);
      lat_freq  = dds.DDS_FREQ;
      lat_dfreq = dds.DDS_DFREQ;
      lat_rate  = dds.DDS_RATE;
    end else if ((dds.DDS_REQ || dds.DDS_ACK) &&
                 (dds.DDS_FREQ != lat_freq || dds.DDS_DFREQ != lat_dfreq || dds.DDS_RATE != lat_rate)) begin
      unstable++;
    end
    req_prev = dds.DDS_REQ;
    if (dds.DDS_START && !start_prev) start_rises++;
    start_prev = dds.DDS_START;
    if (dds.DDS_START) start_cycles++;
    if (EN_IZ) iz_cycles++;
    if (EN_PR) pr_cycles++;
    if (EN_IZ && EN_PR) overlap++;
    if (DONE) done_cnt++;
    if (LATE_ERR) late_cnt++;
    if (OVF) ovf_cnt++;
  end

  task automatic clear_counts();
    req_rises = 0; start_rises = 0; start_cycles = 0; iz_cycles = 0; pr_cycles = 0;
    done_cnt = 0; late_cnt = 0; ovf_cnt = 0; overlap = 0; unstable = 0;
    req_times.delete();
    req_freqs.delete();
  endtask

  function automatic logic [63:0] req_time_at(input int i);
    return (req_times.size() > i) ? req_times[i] : '1;
  endfunction

  function automatic logic [63:0] req_freq_at(input int i);
    return (req_freqs.size() > i) ? 64'(req_freqs[i]) : '1;
  endfunction

  task automatic applyStimulus(input logic [TW-1:0] tstart, input logic [NW-1:0] n,
                               input logic mode, input logic [FW-1:0] freq);
    CMD_TSTART = tstart;
    CMD_N      = n;
    CMD_MODE   = mode;
    CMD_FREQ   = freq;
    CMD_DFREQ  = freq + FW'(7);
    CMD_RATE   = freq[RW-1:0] + RW'(3);
    CMD_WR     = 1'b1;
    @(negedge CLK);
    CMD_WR     = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int w = 0;
    while (done_cnt < target && w < budget) begin
      @(negedge CLK);
      w++;
    end
    repeat (2) @(negedge CLK);
    checkOutput(tag, done_cnt, target);
  endtask

  task automatic second_mark(input logic [TW-1:0] value);
    SYS_TIME_SET = value;
    T1HZ = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int w;
    RESET = 1'b1; T1HZ = 1'b0; TIME_ARM = 1'b0; SYS_TIME_SET = '0; ABORT = 1'b0;
    CMD_WR = 1'b0; CMD_TSTART = '0; CMD_N = '0; CMD_MODE = 1'b0;
    CMD_FREQ = '0; CMD_DFREQ = '0; CMD_RATE = '0;
    CMD_TB1 = 3; CMD_TI = 5; CMD_TB2 = 2; CMD_TP = 4;
    vec_count = 0; miscompares = 0;
    clear_counts();
    repeat (3) @(negedge CLK);
    checkOutput("rst_time", TIME, 0);
    checkOutput("rst_valid", TIME_VALID, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_level", CMD_LEVEL, 0);
    checkOutput("rst_req", dds.DDS_REQ, 0);
    RESET = 1'b0;

    // Time load at the third edge, then no reload without re-arm
    second_mark(64'd1000);
    checkOutput("load_time", TIME, 1000);
    checkOutput("load_valid", TIME_VALID, 1);
    @(negedge CLK);
    checkOutput("time_inc", TIME, 1001);
    T1HZ = 1'b0;
    repeat (4) @(negedge CLK);
    second_mark(64'd5);
    T1HZ = 1'b0;
    checkOutput("no_reload", TIME, 1008);

    // Incoherent burst
    clear_counts();
    applyStimulus(64'd1100, 16'd2, 1'b0, 48'h0000_1234_5678);
    wait_done(1, 400, "inc_done");
    checkOutput("inc_req_cnt", req_rises, 2);
    checkOutput("inc_req_time", req_time_at(0), 1101);
    checkOutput("inc_freq", lat_freq, 48'h0000_1234_5678);
    checkOutput("inc_dfreq", lat_dfreq, 48'h0000_1234_567F);
    checkOutput("inc_rate", lat_rate, 32'h1234_567B);
    checkOutput("inc_iz_cycles", iz_cycles, 12);
    checkOutput("inc_pr_cycles", pr_cycles, 10);
    checkOutput("inc_start_cycles", start_cycles, 12);
    checkOutput("inc_start_rises", start_rises, 2);
    checkOutput("inc_unstable", unstable, 0);
    checkOutput("inc_overlap", overlap, 0);

    // Coherent burst
    clear_counts();
    applyStimulus(64'd1300, 16'd2, 1'b1, 48'h0000_0000_C0DE);
    wait_done(1, 400, "coh_done");
    checkOutput("coh_req_cnt", req_rises, 1);
    checkOutput("coh_req_time", req_time_at(0), 1301);
    checkOutput("coh_start_rises", start_rises, 1);
    checkOutput("coh_start_cycles", start_cycles, 24);
    checkOutput("coh_iz_cycles", iz_cycles, 12);
    checkOutput("coh_pr_cycles", pr_cycles, 10);

    // Re-arm, reload to 900, late command then an on-time one
    clear_counts();
    TIME_ARM = 1'b1;
    @(negedge CLK);
    TIME_ARM = 1'b0;
    checkOutput("arm_clear", TIME_VALID, 0);
    second_mark(64'd900);
    T1HZ = 1'b0;
    checkOutput("reload_time", TIME, 900);
    applyStimulus(64'd500, 16'd1, 1'b0, 48'h0000_0000_0BAD);
    applyStimulus(64'd1000, 16'd1, 1'b0, 48'h0000_0000_0600);
    repeat (4) @(negedge CLK);
    checkOutput("late_pulse", late_cnt, 1);
    checkOutput("late_no_req", req_rises, 0);
    wait_done(1, 300, "late_next_done");
    checkOutput("late_next_time", req_time_at(0), 1001);
    checkOutput("late_next_freq", req_freq_at(0), 64'h0600);

    // Overflow with time invalid so nothing is popped, then abort beats a write
    clear_counts();
    TIME_ARM = 1'b1;
    @(negedge CLK);
    TIME_ARM = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(64'd3000 + 64'(i), 16'd1, 1'b0, 48'(i));
    checkOutput("ovf_level", CMD_LEVEL, DEPTH);
    checkOutput("ovf_full", CMD_FULL, 1);
    @(negedge CLK);
    checkOutput("ovf_pulses", ovf_cnt, 1);
    CMD_WR = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    CMD_WR = 1'b0;
    ABORT = 1'b0;
    checkOutput("abort_flush_level", CMD_LEVEL, 0);
    checkOutput("abort_flush_full", CMD_FULL, 0);

    // FIFO order across three back-to-back commands
    clear_counts();
    applyStimulus(64'd2100, 16'd1, 1'b0, 48'h111);
    applyStimulus(64'd2140, 16'd1, 1'b0, 48'h222);
    applyStimulus(64'd2180, 16'd1, 1'b0, 48'h333);
    checkOutput("order_level", CMD_LEVEL, 3);
    second_mark(64'd2000);
    T1HZ = 1'b0;
    wait_done(3, 600, "order_done");
    checkOutput("order_req_cnt", req_rises, 3);
    checkOutput("order_freq0", req_freq_at(0), 64'h111);
    checkOutput("order_freq1", req_freq_at(1), 64'h222);
    checkOutput("order_freq2", req_freq_at(2), 64'h333);
    checkOutput("order_time0", req_time_at(0), 2101);
    checkOutput("order_time1", req_time_at(1), 2141);
    checkOutput("order_time2", req_time_at(2), 2181);

    // Abort during IZL with three commands queued behind
    clear_counts();
    applyStimulus(64'd2300, 16'd2, 1'b0, 48'hA0);
    applyStimulus(64'd2500, 16'd1, 1'b0, 48'hA1);
    applyStimulus(64'd2600, 16'd1, 1'b0, 48'hA2);
    applyStimulus(64'd2700, 16'd1, 1'b0, 48'hA3);
    checkOutput("abort_pre_level", CMD_LEVEL, 3);
    w = 0;
    while (!EN_IZ && w < 300) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("abort_iz_reached", EN_IZ, 1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checkOutput("abort_en_iz", EN_IZ, 0);
    checkOutput("abort_en_pr", EN_PR, 0);
    checkOutput("abort_start", dds.DDS_START, 0);
    checkOutput("abort_req", dds.DDS_REQ, 0);
    checkOutput("abort_level", CMD_LEVEL, 0);
    checkOutput("abort_busy", BUSY, 0);
    repeat (40) @(negedge CLK);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_no_req", req_rises, 1);

    // Reset while the handshake is pending
    clear_counts();
    applyStimulus(64'd2400, 16'd1, 1'b0, 48'hB0);
    w = 0;
    while (!dds.DDS_REQ && w < 300) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("rst_load_reached", dds.DDS_REQ, 1);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("rst_mid_req", dds.DDS_REQ, 0);
    checkOutput("rst_mid_busy", BUSY, 0);
    checkOutput("rst_mid_time", TIME, 0);
    checkOutput("rst_mid_valid", TIME_VALID, 0);
    checkOutput("rst_mid_level", CMD_LEVEL, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule

// File: doc/master_start_seq.md
Name: master_start_seq

Overview:
- Parametrised successor to the radar master-start sequencer.
- Holds a queue of timed burst commands in a DEPTH-entry FIFO, keeps system time aligned to the 1 Hz second mark, and starts each command exactly when system time matches its start stamp.
- Generates the blank/emit/blank/receive pulse train, and programs the DDS over a REQ/ACK four-phase handshake once per pulse (incoherent) or once per burst (coherent).
- Adds over the single-register generation: command queue, late-command rejection, abort, overflow and done reporting.

Parameters:
TW, 64, system time / start stamp width
FW, 48, DDS frequency and delta-frequency width
RW, 32, DDS delta-rate width
IW, 32, interval width (Tb1, Ti, Tb2, Tp)
NW, 16, pulse-count width
DEPTH, 8, command FIFO entries, power of two, >=2

Ports:
CLK  in  1  clock, 48 MHz
RESET  in  1  synchronous, active-high
T1HZ  in  1  asynchronous second mark
TIME_ARM  in  1  rising edge re-arms time load at the next second mark
SYS_TIME_SET  in  TW  value loaded into TIME at the second mark
CMD_WR  in  1  push one command
CMD_TSTART  in  TW  start stamp
CMD_N  in  NW  number of pulses
CMD_MODE  in  1  0 = incoherent, 1 = coherent
CMD_FREQ / CMD_DFREQ  in  FW  DDS start frequency / step
CMD_RATE  in  RW  DDS step rate
CMD_TB1 / CMD_TI / CMD_TB2 / CMD_TP  in  IW  interval lengths
ABORT  in  1  synchronous abort and flush
DDS_FREQ / DDS_DFREQ  out  FW  handshake data
DDS_RATE  out  RW  handshake data
DDS_REQ  out  1  data valid request
DDS_ACK  in  1  DDS acknowledge (already CDC-synchronised)
DDS_START  out  1  DDS run
EN_IZ / EN_PR  out  1  emit / receive enables
TIME  out  TW  system time
TIME_VALID  out  1  time has been loaded from a second mark
CMD_LEVEL  out  log2(DEPTH)+1  FIFO occupancy
CMD_FULL  out  1  FIFO full
BUSY  out  1  FSM not in IDLE
DONE / LATE_ERR / OVF  out  1  one-cycle pulses

Behaviour:
- Reset: all outputs 0, TIME = 0, FIFO empty, FSM in IDLE. This includes reset mid-burst.
- Time:
  - T1HZ passes through a 2-flop synchroniser; a rising edge is detected on the third flop.
  - Rising edge of TIME_ARM clears TIME_VALID.
  - Second-mark edge with TIME_VALID = 0: TIME <= SYS_TIME_SET, TIME_VALID <= 1. TIME shows the value after the 3rd CLK edge counting the one that first samples T1HZ = 1.
  - Otherwise TIME increments by 1 every cycle and wraps modulo 2^TW.
- FIFO:
  - CMD_WR while not full writes the entry; CMD_LEVEL updates the next cycle.
  - CMD_WR while full drops the command and pulses OVF.
  - A simultaneous push and pop is legal and leaves the level unchanged.
- FSM states: IDLE, WAIT, LOAD, ACKW, BLANK1, IZL, BLANK2, PR.
  - IDLE: when TIME_VALID = 1 and FIFO not empty, pop the head into working registers and go to WAIT.
  - WAIT:
    - TIME == tstart: if N == 0, pulse DONE and go to IDLE; otherwise go to LOAD.
    - TIME > tstart (unsigned): pulse LATE_ERR, discard the command, go to IDLE.
  - LOAD: drive DDS_* data and assert DDS_REQ. Stay until DDS_ACK = 1, then deassert DDS_REQ and go to ACKW.
  - ACKW: wait for DDS_ACK = 0, then go to BLANK1. DDS_* data stays stable from REQ rise until ACK fall.
  - Interval states: each lasts exactly (interval + 1) cycles (BLANK1 = Tb1, IZL = Ti, BLANK2 = Tb2, PR = Tp). The counter is IW bits, loaded on state entry.
  - BLANK1: EN_IZ = 0, EN_PR = 0.
  - IZL: DDS_START = 1 and EN_IZ = 1 from the first IZL cycle.
  - BLANK2: EN_IZ = 0. DDS_START drops to 0 unless MODE = 1 and pulses remain.
  - PR: EN_PR = 1.
  - End of PR: decrement the remaining-pulse count and set EN_PR = 0.
    - Count still > 0: MODE = 0 goes to LOAD; MODE = 1 goes to BLANK1 with no DDS reload.
    - Count reaches 0: pulse DONE and go to IDLE.
- ABORT (any state):
  - Next cycle: FSM to IDLE, DDS_REQ/DDS_START/EN_IZ/EN_PR = 0, FIFO flushed.
  - ABORT has priority over CMD_WR in the same cycle.
- TIME_VALID falling while not IDLE: same as abort, but the FIFO is preserved.

Test Plan:
- T1HZ pulse with SYS_TIME_SET = 1000 -> TIME = 1000 on the 3rd edge after sampling, 1001 next, TIME_VALID = 1. A second T1HZ pulse without TIME_ARM does not reload TIME.
- Incoherent command: tstart = 1100, N = 2, Tb1 = 3, Ti = 5, Tb2 = 2, Tp = 4, ACK returned 2 cycles after REQ -> two DDS handshakes, EN_IZ high 6 cycles per pulse, EN_PR high 5 cycles per pulse, DONE once.
- Same command with MODE = 1 -> one handshake only, DDS_START continuously high from the first IZL until the last BLANK2.
- Push tstart = 500 when TIME = 900 -> LATE_ERR pulse, no REQ, next queued command still runs on time.
- Push DEPTH+1 commands -> CMD_FULL = 1, one OVF pulse, CMD_LEVEL = DEPTH; three back-to-back commands execute in FIFO order.
- ABORT during IZL with 3 queued commands -> all enables low the next cycle, CMD_LEVEL = 0, BUSY = 0. RESET mid-LOAD -> DDS_REQ = 0.
